can_bit_destuff: RTL

//  Receive-side CAN 2.0A/B bit destuffer and frame-field tracker. It sits directly upstream of the CRC LFSR.
//  - Input: sampled bus bits from bit timing, one bit per bit_strobe.
//  - Function: finds SOF, removes stuff bits, checks the stuffing rule, walks the frame fields.
//  - Output to CRC (din/crc_en): dout/crc_en for SOF..last data bit.
//  - Output to CRC compare: dout/crc_field_en for the 15 received CRC bits.

---
 rtl/can_bit_destuff.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/can_bit_destuff.sv
// CAN 2.0A/B receive bit destuffer and frame-field tracker.
// Feeds destuffed bits to the CRC LFSR and the CRC compare stage.
module can_bit_destuff #(
    parameter int IDLE_BITS = 11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_strobe,
    output logic       dout,
    output logic       crc_en,
    output logic       crc_field_en,
    output logic       ide,
    output logic       rtr,
    output logic [3:0] dlc,
    output logic       busy,
    output logic       frame_done,
    output logic       stuff_err
);
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

    typedef enum logic [2:0] {
        INTEG, IDLE, HDR, DATA, CRC, TAIL
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [2:0]    run_cnt_q, run_cnt_d;
    logic          run_val_q, run_val_d;
    logic [5:0]    fcnt_q, fcnt_d;
    logic [5:0]    last_q, last_d;
    logic          b11_q, b11_d;
    logic [2:0]    sdlc_q, sdlc_d;
    logic          dout_d, crc_en_d, crc_field_en_d;
    logic          ide_d, rtr_d, busy_d;
    logic [3:0]    dlc_d;
    logic          frame_done_d, stuff_err_d;
    logic [2:0]    run_inc;
    logic [3:0]    dlc_n;
    logic [6:0]    nbits;
    logic [5:0]    dlc_first, dlc_last;

    // State and output registers; every output is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= INTEG;
            idle_q       <= '0;
            run_cnt_q    <= '0;
            run_val_q    <= 1'b0;
            fcnt_q       <= '0;
            last_q       <= '0;
            b11_q        <= 1'b0;
            sdlc_q       <= '0;
            dout         <= 1'b0;
            crc_en       <= 1'b0;
            crc_field_en <= 1'b0;
            ide          <= 1'b0;
            rtr          <= 1'b0;
            dlc          <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            stuff_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_q       <= idle_d;
            run_cnt_q    <= run_cnt_d;
            run_val_q    <= run_val_d;
            fcnt_q       <= fcnt_d;
            last_q       <= last_d;
            b11_q        <= b11_d;
            sdlc_q       <= sdlc_d;
            dout         <= dout_d;
            crc_en       <= crc_en_d;
            crc_field_en <= crc_field_en_d;
            ide          <= ide_d;
            rtr          <= rtr_d;
            dlc          <= dlc_d;
            busy         <= busy_d;
            frame_done   <= frame_done_d;
            stuff_err    <= stuff_err_d;
        end
    end

    // Next state: integration, SOF, stuff rule and field walk
    always_comb begin
        state_d        = state_q;
        idle_d         = idle_q;
        run_cnt_d      = run_cnt_q;
        run_val_d      = run_val_q;
        fcnt_d         = fcnt_q;
        last_d         = last_q;
        b11_d          = b11_q;
        sdlc_d         = sdlc_q;
        dout_d         = dout;
        crc_en_d       = 1'b0;
        crc_field_en_d = 1'b0;
        ide_d          = ide;
        rtr_d          = rtr;
        dlc_d          = dlc;
        busy_d         = busy;
        frame_done_d   = 1'b0;
        stuff_err_d    = 1'b0;
        run_inc        = (bit_in == run_val_q) ?
                         run_cnt_q + 3'd1 : 3'd1;
        dlc_n          = {sdlc_q, bit_in};
        nbits          = dlc_n[3] ? 7'd64 :
                         {1'b0, dlc_n[2:0], 3'b000};
        dlc_first      = ide ? 6'd34 : 6'd14;
        dlc_last       = ide ? 6'd37 : 6'd17;
        if (bit_strobe) begin
            unique case (state_q)
                INTEG: begin
                    if (!bit_in) begin
                        idle_d = '0;
                    end else if (idle_q == IDLE_LAST) begin
                        state_d = IDLE;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (!bit_in) begin
                        dout_d    = 1'b0;
                        crc_en_d  = 1'b1;
                        run_cnt_d = 3'd1;
                        run_val_d = 1'b0;
                        busy_d    = 1'b1;
                        fcnt_d    = '0;
                        state_d   = HDR;
                    end
                end
                default: begin
                    if (run_cnt_q == 3'd5) begin
                        if (bit_in == run_val_q) begin
                            stuff_err_d = 1'b1;
                            busy_d      = 1'b0;
                            state_d     = INTEG;
                            idle_d      = bit_in ? IW'(1) : '0;
                        end else begin
                            run_val_d = bit_in;
                            run_cnt_d = 3'd1;
                            if (state_q == TAIL) begin
                                frame_done_d = 1'b1;
                                busy_d       = 1'b0;
                                state_d      = INTEG;
                                idle_d       = '0;
                            end
                        end
                    end else begin
                        run_val_d = bit_in;
                        run_cnt_d = run_inc;
                        dout_d    = bit_in;
                        fcnt_d    = fcnt_q + 6'd1;
                        if (state_q == HDR) begin
                            crc_en_d = 1'b1;
                            if (fcnt_q == 6'd11)
                                b11_d = bit_in;
                            if (fcnt_q == 6'd12) begin
                                ide_d = bit_in;
                                if (!bit_in)
                                    rtr_d = b11_q;
                            end
                            if (ide && fcnt_q == 6'd31)
                                rtr_d = bit_in;
                            if (fcnt_q >= dlc_first &&
                                fcnt_q != dlc_last)
                                sdlc_d = {sdlc_q[1:0], bit_in};
                            if (fcnt_q == dlc_last) begin
                                dlc_d  = dlc_n;
                                fcnt_d = '0;
                                last_d = 6'(nbits - 7'd1);
                                if (rtr || dlc_n == 4'd0)
                                    state_d = CRC;
                                else
                                    state_d = DATA;
                            end
                        end else if (state_q == DATA) begin
                            crc_en_d = 1'b1;
                            if (fcnt_q == last_q) begin
                                fcnt_d  = '0;
                                state_d = CRC;
                            end
                        end else if (state_q == CRC) begin
                            crc_field_en_d = 1'b1;
                            if (fcnt_q == 6'd14) begin
                                if (run_inc == 3'd5) begin
                                    state_d = TAIL;
                                end else begin
                                    frame_done_d = 1'b1;
                                    busy_d       = 1'b0;
                                    state_d      = INTEG;
                                    idle_d       = '0;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end
endmodule
